// File: rtl/mux_pkg.sv
// Shared types and helpers for the 4-source round-robin mux/arbiter.
package mux_pkg;

  localparam int SRC_N = 4;
  localparam int SRC_W = 2;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  // Returns {found, idx}: first set valid bit at or above ptr, wrapping 3->0.
  function automatic logic [SRC_W:0] rr_pick(input logic [SRC_N-1:0] valid,
                                             input logic [SRC_W-1:0] ptr);
    logic             found;
    logic [SRC_W-1:0] idx;
    logic [SRC_W-1:0] cand;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < SRC_N; k++) begin
      cand = ptr + SRC_W'(k);
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way rotate/priority encoder for round-robin arbiters.
module rr_pick4
  import mux_pkg::*;
(
  input  logic [SRC_N-1:0] valid,
  input  logic [SRC_W-1:0] ptr,
  output logic             found,
  output logic [SRC_W-1:0] idx
);

  assign {found, idx} = rr_pick(valid, ptr);

endmodule

// File: rtl/mux_4x1_rr_arb.sv
// 4:1 valid/ready mux with round-robin arbitration, optional packet locking,
// and a registered output stage tagged with the source index.
module mux_4x1_rr_arb
  import mux_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int PKT_MODE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SRC_N-1:0]        in_valid,
  input  logic [SRC_N*DATA_W-1:0] in_data,
  input  logic [SRC_N-1:0]        in_last,
  output logic [SRC_N-1:0]        in_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  output logic [SRC_W-1:0]        out_sel,
  input  logic                    out_ready
);

  state_t           state, state_nxt;
  logic [SRC_W-1:0] rr_ptr, ptr_nxt;
  logic [SRC_W-1:0] lock_src, lock_nxt;
  logic             pick_found;
  logic [SRC_W-1:0] pick_idx;
  logic             load_en;
  logic             load;
  logic [SRC_W-1:0] load_src;
  logic             load_last;
  logic [DATA_W-1:0] src_data [SRC_N];

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic              last_p1;
  logic [SRC_W-1:0]  sel_p1;

  for (genvar g = 0; g < SRC_N; g++) begin : g_split
    assign src_data[g] = in_data[g*DATA_W +: DATA_W];
  end

  rr_pick4 u_pick (
    .valid (in_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign load_en   = !vld_p1 || out_ready;
  assign load_last = (PKT_MODE != 0) ? in_last[load_src] : 1'b1;

  // Stage 0: grant selection; reset forces every in_ready low.
  always_comb begin
    in_ready  = '0;
    load      = 1'b0;
    load_src  = pick_idx;
    state_nxt = state;
    ptr_nxt   = rr_ptr;
    lock_nxt  = lock_src;
    case (state)
      ARB: begin
        if (pick_found && load_en) begin
          in_ready[pick_idx] = 1'b1;
          load               = 1'b1;
          ptr_nxt            = pick_idx + 2'd1;
          if (PKT_MODE != 0 && !in_last[pick_idx]) begin
            state_nxt = LOCK;
            lock_nxt  = pick_idx;
          end
        end
      end
      LOCK: begin
        load_src           = lock_src;
        in_ready[lock_src] = load_en;
        load               = load_en && in_valid[lock_src];
        if (load && in_last[lock_src]) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
    if (!rst_n) begin
      in_ready = '0;
      load     = 1'b0;
    end
  end

  // Stage 1: output register plus arbiter control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB;
      rr_ptr   <= '0;
      lock_src <= '0;
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      last_p1  <= 1'b0;
      sel_p1   <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= ptr_nxt;
      lock_src <= lock_nxt;
      if (load) begin
        vld_p1  <= 1'b1;
        data_p1 <= src_data[load_src];
        last_p1 <= load_last;
        sel_p1  <= load_src;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_last  = last_p1;
  assign out_sel   = sel_p1;

endmodule

// File: doc/mux_4x1_rr_arb.md
Name: mux_4x1_rr_arb

Overview:
- Gathers four valid/ready source channels onto one output channel; the companion to the 1x4 demux fan-out path.
- Round-robin arbitration between sources, with packet locking: a granted source keeps the output until its last beat.
- Registered output stage with a 2-bit source tag, so a downstream 1x4 demux can route responses back to the right source.

Parameters:
- DATA_W, 8, width of each data beat.
- PKT_MODE, 1, 1 = hold grant until in_last beat accepted; 0 = re-arbitrate every beat.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  4  per-source beat valid, bit i = source i.
- in_data  in  4*DATA_W  source i data at bits [i*DATA_W +: DATA_W].
- in_last  in  4  per-source last beat of packet (ignored when PKT_MODE=0).
- in_ready  out  4  per-source accept; at most one bit high per cycle.
- out_valid  out  1  output register holds a beat.
- out_data  out  DATA_W  registered beat.
- out_last  out  1  registered last flag (forced 1 when PKT_MODE=0).
- out_sel  out  2  source index of the beat in the output register.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_last=0, out_sel=0, rr_ptr=0, lock_src=0, state=ARB. in_ready=0 while rst_n=0.
- load_en = !out_valid | out_ready. No source may be accepted when load_en=0; all in_ready are 0.
- Transfer on input i: in_valid[i] & in_ready[i]. The beat lands in the output register at the next edge, so latency is 1 cycle.
- Output beat retires on out_valid & out_ready. If there is no new load in the same cycle, out_valid clears. Back-to-back throughput is 1 beat/cycle.
- FSM states: ARB and LOCK.
- ARB state:
  - Winner = first set in_valid bit, searching from rr_ptr upward and wrapping 3->0.
  - If load_en, in_ready[winner]=1 and the register loads winner data, last, and out_sel=winner.
  - On that load, rr_ptr <= winner+1 (mod 4).
  - If PKT_MODE=1 and the loaded beat has last=0, go to LOCK with lock_src=winner.
- LOCK state:
  - Only lock_src is eligible: in_ready[lock_src] = load_en; every other in_ready is 0.
  - When a lock_src beat with last=1 is accepted, return to ARB.
  - rr_ptr is unchanged while in LOCK.
- No in_valid set in ARB: no load and no pointer change.
- Idle cycles in LOCK (lock_src valid low): remain in LOCK, with no timeout.
- Sources must keep in_valid/in_data stable until accepted. The block does not check this.
- Reset mid-packet: the FSM returns to ARB and the output beat is dropped. Upstream is responsible for restarting the packet.

Decomposition:
- Shared package mux_pkg holds:
  - SRC_N = 4 and SRC_W = 2.
  - A state enum {ARB, LOCK}.
  - A function rr_pick(valid[3:0], ptr[1:0]) returning {found, idx[1:0]}.
- One sub-module rr_pick4: combinational 4-way rotate/priority-encode, reusable by other arbiters.
- The top level holds the FSM, rr_ptr, and the output register.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles with in_valid=4'b1111 -> in_ready=0 and out_valid=0. After release, first grant goes to src0; out_sel=0 one cycle after acceptance.
- Fairness (PKT_MODE=0, out_ready=1, all four sources continuously valid, single-beat) -> out_sel sequence is 0,1,2,3,0,1, one beat per cycle with no bubbles.
- Backpressure: out_valid=1 with out_ready=0 held for 4 cycles -> in_ready=4'b0000 and out_data stable. Raising out_ready loads the next beat in the same cycle.
- Packet lock (PKT_MODE=1):
  - src2 sends a 3-beat packet (data 0xA1, 0xA2, 0xA3; last on the third beat) while src0 and src3 are also valid.
  - Required: out_sel=2 for all three beats.
  - Next grant goes to src3 (ptr=3), then src0.
- Lock gap: src1 locked with in_valid dropped for 2 cycles mid-packet while src0 is valid -> src0 is not granted; src1 resumes and completes; ARB then resumes.
- Async reset mid-packet: assert rst_n low between edges while in LOCK with out_valid=1 -> out_valid falls immediately. After release, state=ARB and rr_ptr=0.
